uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated FIFO, replacing the separate generator-to-FIFO-to-uartout chain with a single block. Producers such as chargen push words through an active-low write strobe; the block serialises them onto the TX line. Word width, FIFO depth, baud divisor and stop-bit count are parameters. The block adds a fill-level output, a sticky overflow flag and optional parity.

Parameters:
DATA_BITS, 8, bits per character, legal range 5..8
FIFO_DEPTH, 16, FIFO entries, power of two, minimum 2
CDIV, 434, clocks per bit period, minimum 2
STOP_BITS, 1, stop bits per frame, legal values 1 or 2
LVL_W, $clog2(FIFO_DEPTH+1), width of the level output (derived localparam)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
port  in  DATA_BITS  write data
n_wr  in  1  active-low write strobe; one word per low cycle
n_full  out  1  low when the FIFO is full (registered)
n_empty  out  1  low when the FIFO is empty (registered)
level  out  LVL_W  current FIFO occupancy
ovf  out  1  sticky overflow flag, set by a write while full
ovf_clr  in  1  synchronous clear of ovf
parity_odd  in  1  parity sense (used only with UART_PARITY_EN)
busy  out  1  high while a frame is on the line
tx  out  1  serial output, idles high

Behaviour:
- Reset (async, rst=1): tx=1, busy=0, level=0, n_empty=0, n_full=1, ovf=0. FIFO pointers and the baud counter are cleared. A frame in flight is aborted and tx goes high immediately.
- Write: on a rising edge with n_wr=0 and n_full=1, `port` is stored. A write with n_full=0 is dropped and sets ovf on the next edge. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: level is unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. level is ptr_wr-ptr_rd, with a separate full bit to disambiguate.
- ovf_clr=1 clears ovf. If a set and a clear happen in the same cycle, the set wins.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is not empty, pop the head into the shift register and go to START. busy=1 from the next cycle.
  - START: tx=0 for CDIV clocks.
  - DATA: DATA_BITS bits, LSB first, each held CDIV clocks.
  - PARITY: present only with the macro; one bit period.
  - STOP: tx=1 for STOP_BITS*CDIV clocks, then return to IDLE.
- Baud counter counts down from CDIV-1 to 0; the bit/state advances when it reaches 0.
- Latency: a write at edge t makes n_empty=1 at t+1. If the FIFO is idle, the pop happens at t+1 and tx falls at t+2.
- Back-to-back frames: the pop happens in the final STOP cycle, so there are no idle clocks between frames.
- level is updated on the same edge as the push or pop. n_full and n_empty are derived from the next-state level, with no extra lag.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state is inserted after DATA. The bit is XOR of the data bits (even parity), inverted when parity_odd=1. parity_odd is sampled at pop time.
- Undefined: the PARITY state is absent and parity_odd is ignored. The frame is 1 + DATA_BITS + STOP_BITS bits.

Decomposition:
- Shared package uart_pkg holds:
  - TX state enum
  - constants IDLE_LEVEL=1 and START_LEVEL=0
  - a parity function
- The FIFO storage and pointer logic goes in one sub-module, sync_fifo, parametrised by WIDTH and DEPTH, exposing level, n_full and n_empty.
- The serialiser FSM stays in uart_tx_fifo.

Test Plan:
- Reset/idle: assert rst mid-frame -> tx=1 within the same cycle, level=0, n_empty=0, busy=0 after release.
- Single frame, CDIV=4, DATA_BITS=8, STOP_BITS=1: write 8'h41 -> tx goes low 2 cycles after the write. Bit sequence is 0,1,0,0,0,0,0,1,0,1, each held 4 clocks, then idle.
- Fill/overflow, FIFO_DEPTH=4: 5 writes on consecutive cycles while the line is busy -> level reaches 4, n_full=0, the 5th word is dropped, ovf=1. ovf_clr -> ovf=0.
- Back-to-back with wrap: push 20 words ("a"..."t") at DEPTH=16 with writes throttled on n_full -> 20 frames in order, no gap between a stop bit and the next start bit.
- Parity (UART_PARITY_EN, DATA_BITS=7): 7'h41 -> parity bit 0 with parity_odd=0, 1 with parity_odd=1. STOP_BITS=2 gives 8 clocks high at CDIV=4.
- Push and pop in the same cycle at level=1 -> level stays 1, no ovf.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter with integrated FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Even parity over the (zero-extended) character, flipped for odd sense.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrapping pointers plus a full bit, registered full/empty flags.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             n_full,
  output logic             n_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr_wr;
  logic [AW-1:0]    ptr_rd;
  logic             full_q;
  logic             empty_q;
  logic             push;
  logic             pop;
  logic [LVL_W-1:0] level_nxt;

  // A write while full is refused even if a pop happens on the same edge.
  assign push    = wr_en && !full_q;
  assign pop     = rd_en && !empty_q;
  assign level   = {full_q, AW'(ptr_wr - ptr_rd)};
  assign rd_data = mem[ptr_rd];
  assign n_full  = !full_q;
  assign n_empty = !empty_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LVL_W'(1);
    else if (pop && !push)
      level_nxt = level - LVL_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_wr  <= '0;
      ptr_rd  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push)
        ptr_wr <= ptr_wr + AW'(1);
      if (pop)
        ptr_rd <= ptr_rd + AW'(1);
      full_q  <= (level_nxt == LVL_W'(DEPTH));
      empty_q <= (level_nxt == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[ptr_wr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; optional parity bit via UART_PARITY_EN.
// tx is registered one clock behind the FSM state, so a frame starts two clocks after its write.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_BITS  = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int CDIV       = 434,
  parameter  int STOP_BITS  = 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] port,
  input  logic                 n_wr,
  output logic                 n_full,
  output logic                 n_empty,
  output logic [LVL_W-1:0]     level,
  output logic                 ovf,
  input  logic                 ovf_clr,
  input  logic                 parity_odd,
  output logic                 busy,
  output logic                 tx
);

  localparam int CNT_W = $clog2(CDIV);

  tx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 last_stop;
  logic                 pop;
  logic                 ovf_set;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (!n_wr),
    .wr_data (port),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .n_full  (n_full),
    .n_empty (n_empty)
  );

  // Popping in the final stop cycle chains frames with no idle clock between them.
  assign last_stop = (state == STOP) && (cnt == '0) && (bit_idx == 3'(STOP_BITS - 1));
  assign pop       = n_empty && ((state == IDLE) || last_stop);
  assign ovf_set   = !n_wr && !n_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (ovf_set)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

`ifdef UART_PARITY_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par <= 1'b0;
    else if (pop)
      par <= calc_parity(8'(head), parity_odd);
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      busy    <= 1'b0;
      tx      <= IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (pop) begin
            shift <= head;
            cnt   <= CNT_W'(CDIV - 1);
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          tx <= START_LEVEL;
          if (cnt == '0) begin
            cnt     <= CNT_W'(CDIV - 1);
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DATA: begin
          tx <= shift[0];
          if (cnt == '0) begin
            cnt   <= CNT_W'(CDIV - 1);
            shift <= shift >> 1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          tx <= par;
          if (cnt == '0) begin
            cnt     <= CNT_W'(CDIV - 1);
            bit_idx <= '0;
            state   <= STOP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif

        STOP: begin
          tx <= IDLE_LEVEL;
          if (cnt == '0) begin
            cnt <= CNT_W'(CDIV - 1);
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              if (pop) begin
                shift <= head;
                state <= START;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a frame-level queue model; honours UART_PARITY_EN.
module tb_uart_tx_fifo;

`ifdef UART_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int DEPTH = 4;
  localparam int CDIV  = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int NBITS = 1 + DB + PB + SB;
  localparam int FRAME = NBITS * CDIV;

  logic             clk = 1'b0;
  logic             rst;
  logic [DB-1:0]    port;
  logic             n_wr;
  logic             n_full;
  logic             n_empty;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic             ovf_clr;
  logic             parity_odd;
  logic             busy;
  logic             tx;

  uart_tx_fifo #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH),
    .CDIV       (CDIV),
    .STOP_BITS  (SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .port       (port),
    .n_wr       (n_wr),
    .n_full     (n_full),
    .n_empty    (n_empty),
    .level      (level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .parity_odd (parity_odd),
    .busy       (busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a queue of accepted words and the bit pattern of the frame on the line.
  logic [DB-1:0] q [$];
  logic [15:0]   fb;
  bit            busy_m = 1'b0;
  int            pos    = 0;
  logic          tx_m   = 1'b1;
  logic          ovf_m  = 1'b0;
  int            old_sz;
  bit            done_m;

  function automatic logic [15:0] make_frame(input logic [DB-1:0] d, input logic po);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++)
      f[1 + i] = d[i];
`ifdef UART_PARITY_EN
    f[1 + DB] = (^d) ^ po;
`endif
    return f;
  endfunction

  always begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      busy_m = 1'b0;
      pos    = 0;
      tx_m   = 1'b1;
      ovf_m  = 1'b0;
    end else begin
      old_sz = q.size();
      done_m = 1'b0;
      if (busy_m) begin
        tx_m = fb[pos / CDIV];
        pos++;
        done_m = (pos == FRAME);
      end else begin
        tx_m = 1'b1;
      end
      if ((!busy_m || done_m) && old_sz > 0) begin
        fb     = make_frame(q.pop_front(), parity_odd);
        pos    = 0;
        busy_m = 1'b1;
      end else if (done_m) begin
        busy_m = 1'b0;
      end
      if (!n_wr && old_sz < DEPTH)
        q.push_back(port);
      if (!n_wr && old_sz == DEPTH)
        ovf_m = 1'b1;
      else if (ovf_clr)
        ovf_m = 1'b0;
    end
    #1;
    check("tx", 32'(tx), 32'(tx_m));
    check("busy", 32'(busy), 32'(busy_m));
    check("level", 32'(level), 32'(q.size()));
    check("n_empty", 32'(n_empty), 32'(q.size() != 0));
    check("n_full", 32'(n_full), 32'(q.size() != DEPTH));
    check("ovf", 32'(ovf), 32'(ovf_m));
  end

  // Inputs change 2 time units after the edge, well clear of both edge and sampling point.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [DB-1:0] d);
    n_wr = 1'b0;
    port = d;
    tick();
    n_wr = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy_m || q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000)
      check({tag, "_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic wait_push_pop_slot();
    int n;
    n = 0;
    while (!(busy_m && pos == FRAME - 1 && q.size() == 1) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500)
      check("pushpop_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_tx_low();
    int n;
    n = 0;
    while (!(busy_m && tx_m == 1'b0) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500)
      check("midframe_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    rst        = 1'b1;
    n_wr       = 1'b1;
    port       = '0;
    ovf_clr    = 1'b0;
    parity_odd = 1'b0;
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_n_empty", 32'(n_empty), 32'(0));
    check("rst_n_full", 32'(n_full), 32'(1));
    check("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    repeat (2) tick();

    // Single frame: 'A' starts two clocks after its write.
    write_word(DB'(8'h41));
    check("single_level", 32'(level), 32'(1));
    check("single_n_empty", 32'(n_empty), 32'(1));
    tick();
    check("single_tx_t1", 32'(tx), 32'(1));
    check("single_busy_t1", 32'(busy), 32'(1));
    tick();
    check("single_tx_t2", 32'(tx), 32'(0));
    wait_idle("single");

`ifdef UART_PARITY_EN
    parity_odd = 1'b1;
    write_word(DB'(8'h41));
    tick();
    parity_odd = 1'b0;
    wait_idle("parity_odd");
`endif

    // Fill while the line is busy: four accepted, the fifth dropped.
    write_word(DB'(8'h11));
    tick();
    for (int i = 0; i < 5; i++) begin
      n_wr = 1'b0;
      port = DB'(8'h20 + i);
      tick();
    end
    n_wr = 1'b1;
    check("fill_level", 32'(level), 32'(DEPTH));
    check("fill_n_full", 32'(n_full), 32'(0));
    check("fill_ovf", 32'(ovf), 32'(1));
    // Set and clear together: set wins.
    n_wr    = 1'b0;
    ovf_clr = 1'b1;
    tick();
    n_wr = 1'b1;
    check("ovf_set_wins", 32'(ovf), 32'(1));
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'(0));
    wait_idle("fill");

    // 20 characters 'a'..'t', throttled on n_full, pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      int n;
      n = 0;
      while (!n_full && n < 500) begin
        tick();
        n++;
      end
      if (n >= 500)
        check("b2b_timeout", 32'(n), 32'(0));
      write_word(DB'(8'h61 + i));
    end
    wait_idle("b2b");

    // Push on the same edge as the pop at level 1.
    write_word(DB'(8'h33));
    write_word(DB'(8'h34));
    wait_push_pop_slot();
    write_word(DB'(8'h35));
    check("pushpop_level", 32'(level), 32'(1));
    check("pushpop_ovf", 32'(ovf), 32'(0));
    wait_idle("pushpop");

    // Random traffic: heavy then light write rates.
    for (int i = 0; i < 1600; i++) begin
      int rate;
      rate       = (i < 800) ? 30 : 4;
      n_wr       = ($urandom_range(0, 99) < rate) ? 1'b0 : 1'b1;
      port       = DB'($urandom);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      parity_odd = 1'($urandom);
      tick();
    end
    n_wr    = 1'b1;
    ovf_clr = 1'b0;

    // Asynchronous reset in the middle of a start/data low bit.
    write_word(DB'(8'h00));
    wait_tx_low();
    #1;
    rst = 1'b1;
    #1;
    check("async_tx", 32'(tx), 32'(1));
    check("async_busy", 32'(busy), 32'(0));
    check("async_level", 32'(level), 32'(0));
    check("async_n_empty", 32'(n_empty), 32'(0));
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_tx", 32'(tx), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
